// File: rtl/fetch_line_buffer.sv
// Instruction fetch stage: fetches 64-bit lines after a fixed latency and issues 16-bit instructions over valid/ready.
// Optional FETCH_STATS_EN adds a line_fetches capture counter port.
module fetch_line_buffer #(
    parameter int unsigned MEM_LAT  = 5,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    input  logic [63:0] mem_line,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] line_fetches
`endif
);

    typedef enum logic {S_WAIT = 1'b0, S_ISSUE = 1'b1} state_t;

    localparam logic [3:0]  LAT_LAST = 4'(MEM_LAT - 1);
    localparam logic [15:0] PC_RST   = RESET_PC & 16'hFFFE;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [12:0] tag_q, tag_d;
    logic [63:0] line_q, line_d;
    logic        line_ok_q, line_ok_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        redir_hit;
    logic        capture;

    assign redir_hit = (state_q == S_ISSUE) && line_ok_q && (redirect_pc[15:3] == tag_q);
    // A redirect on the capture edge abandons the in-flight line
    assign capture   = (state_q == S_WAIT) && (cnt_q == LAT_LAST) && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_WAIT;
            pc_q      <= PC_RST;
            tag_q     <= '0;
            line_q    <= '0;
            line_ok_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tag_q     <= tag_d;
            line_q    <= line_d;
            line_ok_q <= line_ok_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tag_d     = tag_q;
        line_d    = line_q;
        line_ok_d = line_ok_q;
        cnt_d     = cnt_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & 16'hFFFE;
            if (!redir_hit) begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (capture) begin
                        line_d    = mem_line;
                        tag_d     = pc_q[15:3];
                        line_ok_d = 1'b1;
                        state_d   = S_ISSUE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        pc_d = pc_q + 16'd2;
                        if (pc_q[2:1] == 2'd3) begin
                            state_d = S_WAIT;
                            cnt_d   = '0;
                        end
                    end
                end
                default: state_d = S_WAIT;
            endcase
        end
    end

    // Outputs decode registered state only
    always_comb begin
        instr_valid = (state_q == S_ISSUE);
        instr_pc    = pc_q;
        mem_addr    = {pc_q[15:3], 3'b000};
        case (pc_q[2:1])
            2'd0:    instr = line_q[63:48];
            2'd1:    instr = line_q[47:32];
            2'd2:    instr = line_q[31:16];
            default: instr = line_q[15:0];
        endcase
    end

`ifdef FETCH_STATS_EN
    logic [15:0] fetches_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetches_q <= '0;
        end else if (capture) begin
            fetches_q <= fetches_q + 16'd1;
        end
    end

    assign line_fetches = fetches_q;
`endif

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed bench for fetch_line_buffer: per-cycle vector table plus hand-written reset sequences.
module tb_fetch_line_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic [63:0] mem_line;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
`ifdef FETCH_STATS_EN
    logic [15:0] line_fetches;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_line_buffer #(.MEM_LAT(5), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_line       (mem_line),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_STATS_EN
        ,
        .line_fetches   (line_fetches)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: line 0 is the test-plan line, other lines are address-derived
    function automatic logic [63:0] line_of(input logic [15:0] a);
        if (a == 16'h0000) return 64'h0401_250A_1281_2D1E;
        return {a ^ 16'hA000, a ^ 16'hB002, a ^ 16'hC004, a ^ 16'hD006};
    endfunction

    always_comb mem_line = line_of(mem_addr);

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [15:0] rpc;
        logic        v;
        logic [15:0] ins;
        logic [15:0] pc;
        logic [15:0] ma;
        logic [15:0] lf;
    } vec_t;

    localparam int NV = 48;
    vec_t vecs [NV];

    task automatic setv(input int k, input logic rdy, input logic rv, input logic [15:0] rpc,
                        input logic v, input logic [15:0] ins, input logic [15:0] pc,
                        input logic [15:0] ma, input logic [15:0] lf);
        vecs[k].rdy = rdy; vecs[k].rv = rv; vecs[k].rpc = rpc;
        vecs[k].v = v; vecs[k].ins = ins; vecs[k].pc = pc; vecs[k].ma = ma; vecs[k].lf = lf;
    endtask

    task automatic check(input string name, input int k, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at step %0d: got %h, expected %h", name, k, got, want);
        end
    endtask

    task automatic check_stats(input int k, input logic [15:0] want);
`ifdef FETCH_STATS_EN
        check("line_fetches", k, line_fetches, want);
`else
        if (k < 0) $display("unused stats expectation %h", want);
`endif
    endtask

    initial begin
        // k = observation after k edges with reset released; inputs apply to the following edge
        for (int k = 0; k <= 4; k++) setv(k, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        setv(5, 1, 0, 0, 1, 16'h0401, 16'h0000, 16'h0000, 1);
        setv(6, 1, 0, 0, 1, 16'h250A, 16'h0002, 16'h0000, 1);
        setv(7, 1, 0, 0, 1, 16'h1281, 16'h0004, 16'h0000, 1);
        setv(8, 1, 0, 0, 1, 16'h2D1E, 16'h0006, 16'h0000, 1);
        for (int k = 9; k <= 13; k++) setv(k, 1, 0, 0, 0, 16'h0000, 16'h0008, 16'h0008, 1);
        setv(14, 0, 1, 16'h0002, 1, 16'hA008, 16'h0008, 16'h0008, 2);
        for (int k = 15; k <= 19; k++) setv(k, 0, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 2);
        for (int k = 20; k <= 22; k++) setv(k, 0, 0, 0, 1, 16'h250A, 16'h0002, 16'h0000, 3);
        setv(23, 1, 1, 16'h0006, 1, 16'h250A, 16'h0002, 16'h0000, 3);
        setv(24, 1, 0, 0, 1, 16'h2D1E, 16'h0006, 16'h0000, 3);
        setv(25, 1, 0, 0, 0, 16'h0000, 16'h0008, 16'h0008, 3);
        setv(26, 1, 1, 16'h0011, 0, 16'h0000, 16'h0008, 16'h0008, 3);
        for (int k = 27; k <= 31; k++) setv(k, 1, 0, 0, 0, 16'h0000, 16'h0010, 16'h0010, 3);
        setv(32, 1, 1, 16'h0040, 1, 16'hA010, 16'h0010, 16'h0010, 4);
        for (int k = 33; k <= 37; k++) setv(k, 0, 0, 0, 0, 16'h0000, 16'h0040, 16'h0040, 4);
        setv(38, 0, 1, 16'hFFFE, 1, 16'hA040, 16'h0040, 16'h0040, 5);
        for (int k = 39; k <= 43; k++) setv(k, 0, 0, 0, 0, 16'h0000, 16'hFFFE, 16'hFFF8, 5);
        setv(44, 1, 0, 0, 1, 16'h2FFE, 16'hFFFE, 16'hFFF8, 6);
        for (int k = 45; k <= 47; k++) setv(k, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 6);

        reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);

        for (int k = 0; k < NV; k++) begin
            check("instr_valid", k, {15'd0, instr_valid}, {15'd0, vecs[k].v});
            check("instr_pc", k, instr_pc, vecs[k].pc);
            check("mem_addr", k, mem_addr, vecs[k].ma);
            if (vecs[k].v || k == 0) check("instr", k, instr, vecs[k].ins);
            check_stats(k, vecs[k].lf);
            reset          = 1'b0;
            instr_ready    = vecs[k].rdy;
            redirect_valid = vecs[k].rv;
            redirect_pc    = vecs[k].rpc;
            @(negedge clk);
        end

        // Reset in the middle of a fetch of line 0 (line_q still holds line 0xFFF8)
        reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        check("rst_wait_valid", 100, {15'd0, instr_valid}, 16'd0);
        check("rst_wait_instr", 100, instr, 16'h0000);
        check("rst_wait_pc", 100, instr_pc, 16'h0000);
        check("rst_wait_addr", 100, mem_addr, 16'h0000);
        check_stats(100, 16'd0);

        begin
            int n;
            n = 0;
            reset = 1'b0;
            while (!instr_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("reset_latency", 101, 16'(n), 16'd5);
        end
        @(negedge clk);
        check("stall_instr", 102, instr, 16'h0401);
        check("stall_pc", 102, instr_pc, 16'h0000);

        // Reset while issuing
        reset = 1'b1;
        @(negedge clk);
        check("rst_issue_valid", 103, {15'd0, instr_valid}, 16'd0);
        check("rst_issue_instr", 103, instr, 16'h0000);
        reset = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
